// File: rtl/pwm_ramp_seq.sv
// Duty-cycle ramp sequencer: accepts one ramp command and steps high_limit
// from start to end, pulsing para_config_vld once per step with a dwell gap.
module pwm_ramp_seq #(
   parameter int CNT_W = 28
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_period,
   input  logic [CNT_W-1:0] cmd_high_start,
   input  logic [CNT_W-1:0] cmd_high_end,
   input  logic [CNT_W-1:0] cmd_step,
   input  logic [CNT_W-1:0] cmd_dwell,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             para_config_vld,
   output logic [CNT_W-1:0] period_limit,
   output logic [CNT_W-1:0] high_limit
);

   typedef enum logic [3:0] {
      IDLE   = 4'b0001,
      ISSUE  = 4'b0010,
      DWELL  = 4'b0100,
      FINISH = 4'b1000
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cur_q, cur_d;
   logic [CNT_W-1:0] end_q, end_d;
   logic [CNT_W-1:0] step_q, step_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             dir_up_q, dir_up_d;

   logic [CNT_W:0]   sum_w;
   logic [CNT_W:0]   diff_w;
   logic [CNT_W-1:0] next_val;

   // One extra bit keeps the up-step from wrapping; the down-step floors at 0
   // before being clamped against the end value.
   always_comb begin
      sum_w  = {1'b0, cur_q} + {1'b0, step_q};
      diff_w = (cur_q >= step_q) ? {1'b0, cur_q - step_q} : '0;
      if (step_q == '0)
         next_val = end_q;
      else if (dir_up_q)
         next_val = (sum_w >= {1'b0, end_q}) ? end_q : sum_w[CNT_W-1:0];
      else
         next_val = (diff_w <= {1'b0, end_q}) ? end_q : diff_w[CNT_W-1:0];
   end

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      end_d       = end_q;
      step_d      = step_q;
      dwell_d     = dwell_q;
      dwell_cnt_d = dwell_cnt_q;
      period_d    = period_q;
      high_d      = high_q;
      dir_up_d    = dir_up_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               end_d    = cmd_high_end;
               step_d   = cmd_step;
               dwell_d  = cmd_dwell;
               dir_up_d = (cmd_high_end >= cmd_high_start);
               cur_d    = cmd_high_start;
               period_d = cmd_period;
               high_d   = cmd_high_start;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            if (abort)
               state_d = IDLE;
            else if (cur_q == end_q)
               state_d = FINISH;
            else begin
               dwell_cnt_d = '0;
               state_d     = DWELL;
            end
         end
         DWELL: begin
            if (abort)
               state_d = IDLE;
            else if (dwell_cnt_q == dwell_q) begin
               cur_d   = next_val;
               high_d  = next_val;
               state_d = ISSUE;
            end else
               dwell_cnt_d = dwell_cnt_q + 1'b1;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_q       <= '0;
         end_q       <= '0;
         step_q      <= '0;
         dwell_q     <= '0;
         dwell_cnt_q <= '0;
         period_q    <= '0;
         high_q      <= '0;
         dir_up_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         end_q       <= end_d;
         step_q      <= step_d;
         dwell_q     <= dwell_d;
         dwell_cnt_q <= dwell_cnt_d;
         period_q    <= period_d;
         high_q      <= high_d;
         dir_up_q    <= dir_up_d;
      end
   end

   assign cmd_ready       = (state_q == IDLE);
   assign busy            = (state_q != IDLE);
   assign para_config_vld = (state_q == ISSUE);
   assign done            = (state_q == FINISH);
   assign period_limit    = period_q;
   assign high_limit      = high_q;

endmodule
